// File: rtl/axis_i2c_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXIS path into the I2C TX FIFO.
// Optional stall timeout with forced release: define AXIS_I2C_ARB_TIMEOUT_EN.
module axis_i2c_arbiter #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [NUM_SRC-1:0]            grant_o,
  output logic [ID_W-1:0]               grant_id_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  if (NUM_SRC < 2 || NUM_SRC > 16 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("axis_i2c_arbiter: illegal parameter set");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]     cand, win_id, next_ptr;
  logic                win_found, g_valid, beat_acc;

  // First requester at or after rr_ptr, wrapping within NUM_SRC.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_ptr_q;
    cand      = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % int'(NUM_SRC));
      if (!win_found && s_axis_tvalid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign next_ptr = ID_W'((int'(grant_id_q) + 1) % int'(NUM_SRC));
  assign g_valid  = s_axis_tvalid[grant_id_q];
  assign beat_acc = m_axis_tvalid & m_axis_tready;

  // Zero-latency data path; nothing passes while idle.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == ST_GRANT) begin
      m_axis_tdata              = s_axis_tdata[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tvalid             = g_valid;
      m_axis_tlast              = s_axis_tlast[grant_id_q];
      s_axis_tready[grant_id_q] = m_axis_tready;
    end
  end

`ifdef AXIS_I2C_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    grant_d    = grant_q;
`ifdef AXIS_I2C_ARB_TIMEOUT_EN
    stall_d    = stall_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_GRANT;
          grant_id_d = win_id;
          grant_d    = NUM_SRC'(1) << win_id;
        end
`ifdef AXIS_I2C_ARB_TIMEOUT_EN
        stall_d = '0;
`endif
      end
      ST_GRANT: begin
        if (beat_acc && m_axis_tlast) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
`ifdef AXIS_I2C_ARB_TIMEOUT_EN
        // Only an absent granted tvalid counts as a stall, not back-pressure.
        if (beat_acc) begin
          stall_d = '0;
        end else if (!g_valid) begin
          if (stall_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d   = ST_IDLE;
            grant_d   = '0;
            rr_ptr_d  = next_ptr;
            timeout_d = 1'b1;
            stall_d   = '0;
          end else begin
            stall_d = stall_q + CNT_W'(1);
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      grant_q    <= grant_d;
    end
  end

`ifdef AXIS_I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = (state_q == ST_GRANT);

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// Directed bench for axis_i2c_arbiter: per-source packet queues feed the DUT and
// a scoreboard of expected {grant_id, tdata, tlast} beats is popped on each output handshake.
module tb_axis_i2c_arbiter;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned TO_CYC  = 16;
  localparam int unsigned ID_W    = 2;

  logic                    clk;
  logic                    arstn_i;
  logic [NUM_SRC*DW-1:0]   s_tdata;
  logic [NUM_SRC-1:0]      s_tvalid;
  logic [NUM_SRC-1:0]      s_tlast;
  logic [NUM_SRC-1:0]      s_axis_tready;
  logic [DW-1:0]           m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tlast;
  logic                    m_ready;
  logic [NUM_SRC-1:0]      grant_o;
  logic [ID_W-1:0]         grant_id_o;
  logic                    busy_o;
  logic                    timeout_o;

  axis_i2c_arbiter #(
    .NUM_SRC    (NUM_SRC),
    .DATA_WIDTH (DW),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk_i        (clk),
    .arstn_i      (arstn_i),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_ready),
    .grant_o      (grant_o),
    .grant_id_o   (grant_id_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t              src_q[NUM_SRC][$];
  logic [10:0]        exp_q[$];
  int                 gnt_log[$];
  int unsigned        n_checks = 0;
  int unsigned        n_errors = 0;
  int unsigned        to_cnt   = 0;
  logic [NUM_SRC-1:0] hs_vec;
  logic               m_rdy_nxt;
  logic               prev_hold, last_hs, prev_busy;
  logic [DW-1:0]      hold_data;
  logic               hold_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input int k, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[k].push_back(b);
  endtask

  task automatic sb_push(input int id, input logic [DW-1:0] d, input logic l);
    exp_q.push_back({ID_W'(id), d, l});
  endtask

  task automatic drive();
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (src_q[k].size() > 0) begin
        s_tvalid[k]          = 1'b1;
        s_tdata[k*DW +: DW]  = src_q[k][0].data;
        s_tlast[k]           = src_q[k][0].last;
      end else begin
        s_tvalid[k]          = 1'b0;
        s_tdata[k*DW +: DW]  = '0;
        s_tlast[k]           = 1'b0;
      end
    end
  endtask

  // Output-side checks, run at every falling edge.
  task automatic monitor();
    if (prev_hold)
      check("hold_stable", 32'({m_axis_tvalid, m_axis_tdata, m_axis_tlast}), 32'({1'b1, hold_data, hold_last}));
    if (last_hs)
      check("bubble", 32'({busy_o, m_axis_tvalid}), 32'(0));
    if (m_axis_tvalid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        assert (exp_q.size() > 0) else begin
          n_errors++;
          $error("FAIL unexpected_beat observed=0x%0h expected=none",
                 {grant_id_o, m_axis_tdata, m_axis_tlast});
        end
      end else begin
        check("beat", 32'({grant_id_o, m_axis_tdata, m_axis_tlast}), 32'(exp_q.pop_front()));
      end
    end
    last_hs   = m_axis_tvalid && m_ready && m_axis_tlast;
    prev_hold = m_axis_tvalid && !m_ready;
    hold_data = m_axis_tdata;
    hold_last = m_axis_tlast;
    if (busy_o && !prev_busy) gnt_log.push_back(int'(grant_id_o));
    prev_busy = busy_o;
    if (timeout_o === 1'b1) to_cnt++;
    hs_vec = s_tvalid & s_axis_tready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < int'(NUM_SRC); k++)
      if (hs_vec[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    m_ready = m_rdy_nxt;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && exp_q.size() > 0; i++) tick();
    check({tag, "_drain"}, 32'(exp_q.size()), 32'(0));
    for (int i = 0; i < 4 && busy_o; i++) tick();
    check({tag, "_idle"}, 32'({busy_o, grant_o}), 32'(0));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_grant"},   32'(grant_o),       32'(0));
    check({tag, "_gid"},     32'(grant_id_o),    32'(0));
    check({tag, "_busy"},    32'(busy_o),        32'(0));
    check({tag, "_mvalid"},  32'(m_axis_tvalid), 32'(0));
    check({tag, "_sready"},  32'(s_axis_tready), 32'(0));
    check({tag, "_timeout"}, 32'(timeout_o),     32'(0));
  endtask

  task automatic assert_reset();
    arstn_i   = 1'b0;
    hs_vec    = '0;
    prev_hold = 1'b0;
    last_hs   = 1'b0;
    prev_busy = 1'b0;
  endtask

  function automatic logic [31:0] log_code();
    logic [31:0] c = '0;
    foreach (gnt_log[i]) c = (c << 4) | 32'(gnt_log[i] + 1);
    return c;
  endfunction

  initial begin
    arstn_i   = 1'b1;
    m_ready   = 1'b1;
    m_rdy_nxt = 1'b1;
    hs_vec    = '0;
    prev_hold = 1'b0;
    last_hs   = 1'b0;
    prev_busy = 1'b0;
    hold_data = '0;
    hold_last = 1'b0;
    s_tdata   = '0;
    s_tvalid  = '0;
    s_tlast   = '0;
    drive();
    #2;
    assert_reset();
    @(negedge clk);
    #1;
    chk_reset("por");
    tick();
    arstn_i = 1'b1;
    tick();

    // src2 three-beat packet: grant one cycle after tvalid.
    push_beat(2, 8'hA1, 1'b0); push_beat(2, 8'hA2, 1'b0); push_beat(2, 8'hA3, 1'b1);
    sb_push(2, 8'hA1, 1'b0);   sb_push(2, 8'hA2, 1'b0);   sb_push(2, 8'hA3, 1'b1);
    gnt_log.delete();
    tick();
    check("t1_arb_cycle", 32'({busy_o, grant_o}), 32'(0));
    tick();
    check("t1_grant", 32'(grant_o), 32'(4'b0100));
    check("t1_gid", 32'(grant_id_o), 32'(2));
    tick();
    tick();
    tick();
    check("t1_release", 32'({busy_o, grant_o}), 32'(0));
    check("t1_gid_kept", 32'(grant_id_o), 32'(2));
    check("t1_drain", 32'(exp_q.size()), 32'(0));

    // rr_ptr=3: src3 before src0.
    gnt_log.delete();
    push_beat(0, 8'hB0, 1'b1);
    push_beat(3, 8'hB3, 1'b1);
    sb_push(3, 8'hB3, 1'b1);
    sb_push(0, 8'hB0, 1'b1);
    drain("t4", 20);
    check("t4_order", log_code(), 32'h41);

    // src1 with toggling back-pressure.
    for (int b = 0; b < 4; b++) begin
      push_beat(1, DW'(8'h11 + b), b == 3);
      sb_push(1, DW'(8'h11 + b), b == 3);
    end
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      m_rdy_nxt = (i % 2 == 0);
      tick();
      if (busy_o)
        check("t3_sready", 32'(s_axis_tready), 32'({2'b00, m_ready, 1'b0}));
    end
    m_rdy_nxt = 1'b1;
    drain("t3", 10);

    assert_reset();
    #1;
    chk_reset("rst2");
    tick();
    arstn_i = 1'b1;
    tick();

    // All four requesting: order 0,1,2,3,0.
    gnt_log.delete();
    push_beat(0, 8'h50, 1'b0); push_beat(0, 8'h51, 1'b1);
    push_beat(0, 8'h52, 1'b0); push_beat(0, 8'h53, 1'b1);
    push_beat(1, 8'h21, 1'b0); push_beat(1, 8'h22, 1'b1);
    push_beat(2, 8'h31, 1'b0); push_beat(2, 8'h32, 1'b1);
    push_beat(3, 8'h41, 1'b0); push_beat(3, 8'h42, 1'b1);
    sb_push(0, 8'h50, 1'b0); sb_push(0, 8'h51, 1'b1);
    sb_push(1, 8'h21, 1'b0); sb_push(1, 8'h22, 1'b1);
    sb_push(2, 8'h31, 1'b0); sb_push(2, 8'h32, 1'b1);
    sb_push(3, 8'h41, 1'b0); sb_push(3, 8'h42, 1'b1);
    sb_push(0, 8'h52, 1'b0); sb_push(0, 8'h53, 1'b1);
    drain("t2", 60);
    check("t2_order", log_code(), 32'h12341);

    // src1 stalls mid-packet while src2 waits.
    gnt_log.delete();
    to_cnt = 0;
    push_beat(1, 8'hD1, 1'b0);
    push_beat(2, 8'hE0, 1'b0); push_beat(2, 8'hE1, 1'b1);
    sb_push(1, 8'hD1, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    check("to_first_beat", 32'(exp_q.size()), 32'(0));
    tick();
    check("to_held0", 32'({busy_o, timeout_o}), 32'(2'b10));
`ifdef AXIS_I2C_ARB_TIMEOUT_EN
    sb_push(2, 8'hE0, 1'b0); sb_push(2, 8'hE1, 1'b1);
    for (int i = 1; i <= int'(TO_CYC); i++) begin
      tick();
      if (i < int'(TO_CYC)) check("to_wait", 32'({busy_o, timeout_o}), 32'(2'b10));
      else                  check("to_fire", 32'({busy_o, timeout_o}), 32'(2'b01));
    end
    drain("to", 20);
    check("to_pulses", 32'(to_cnt), 32'(1));
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("to_held", 32'({busy_o, grant_id_o, timeout_o}), 32'({1'b1, 2'd1, 1'b0}));
    end
    push_beat(1, 8'hD2, 1'b1);
    sb_push(1, 8'hD2, 1'b1);
    sb_push(2, 8'hE0, 1'b0); sb_push(2, 8'hE1, 1'b1);
    drain("to", 20);
    check("to_pulses", 32'(to_cnt), 32'(0));
`endif
    check("to_order", log_code(), 32'h23);

    // Reset in the middle of a src2 packet.
    push_beat(2, 8'h61, 1'b0); push_beat(2, 8'h62, 1'b0);
    push_beat(2, 8'h63, 1'b0); push_beat(2, 8'h64, 1'b1);
    sb_push(2, 8'h61, 1'b0); sb_push(2, 8'h62, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() > 1; i++) tick();
    tick();
    check("mid_beats", 32'(exp_q.size()), 32'(0));
    assert_reset();
    #1;
    chk_reset("mid_rst");
    src_q[2].delete();
    push_beat(3, 8'h71, 1'b1);
    push_beat(1, 8'h81, 1'b0); push_beat(1, 8'h82, 1'b1);
    sb_push(1, 8'h81, 1'b0); sb_push(1, 8'h82, 1'b1);
    sb_push(3, 8'h71, 1'b1);
    tick();
    tick();
    check("mid_in_rst", 32'({busy_o, m_axis_tvalid, s_axis_tready}), 32'(0));
    gnt_log.delete();
    arstn_i = 1'b1;
    drain("mid", 20);
    check("mid_order", log_code(), 32'h24);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
